// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave exposing a 64 x 32-bit memory in a 256-byte window at BASE_ADDR.
// Define AHB_SLV_ERR_EN to build the two-cycle ERROR response for misses and unaligned accesses.
module ahb_slave_mem #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        hreadyin,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam logic [2:0] WS         = 3'(WAIT_STATES);
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
`ifdef AHB_SLV_ERR_EN
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT} state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  // Registered address-phase information for the transfer now in its data phase.
  logic        valid_q;
  logic        write_q;
  logic        good_q;
  logic [7:0]  addr_q;
  logic [2:0]  size_q;

  logic [31:0] mem [64];

  logic        accept;
  logic        hit;
  logic        aligned;
  logic        complete;
  logic [3:0]  lanes;
  logic [31:0] merged;

  assign hit      = (haddr[31:8] == BASE_ADDR[31:8]);
  assign accept   = hreadyin && hreadyout && (htrans == TR_NONSEQ || htrans == TR_SEQ);
  assign complete = valid_q && hreadyout;

  always_comb begin
    case (hsize)
      3'b000:  aligned = 1'b1;
      3'b001:  aligned = ~haddr[0];
      default: aligned = (haddr[1:0] == 2'b00);
    endcase
  end

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    case (state_q)
      ST_WAIT: hreadyout = (cnt_q == 3'd0);
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
      end
      ST_ERR2: hresp = RESP_ERROR;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = ST_IDLE;
      end
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Acceptance is only possible while hreadyout=1, i.e. on the last cycle of any data phase.
    if (accept) begin
`ifdef AHB_SLV_ERR_EN
      if (!(hit && aligned)) begin
        state_d = ST_ERR1;
      end else
`endif
      if (WS != 3'd0) begin
        state_d = ST_WAIT;
        cnt_d   = WS;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      good_q  <= 1'b0;
      addr_q  <= 8'h00;
      size_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hreadyout) valid_q <= accept;
      if (accept) begin
        write_q <= hwrite;
        good_q  <= hit && aligned;
        addr_q  <= haddr[7:0];
        size_q  <= hsize;
      end
    end
  end

  always_comb begin
    case (size_q)
      3'b000:  lanes = 4'b0001 << addr_q[1:0];
      3'b001:  lanes = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  always_comb begin
    merged = mem[addr_q[7:2]];
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  // NOTE: the storage array has no reset; only control state is cleared, which keeps it mappable to RAM.
  always_ff @(posedge hclk) begin
    if (hresetn && complete && write_q && good_q) begin
      mem[addr_q[7:2]] <= merged;
    end
  end

  assign hrdata = (complete && !write_q && good_q) ? mem[addr_q[7:2]] : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed self-checking bench: one instance with zero wait states, one with three.
module tb_ahb_slave_mem;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;

`ifdef AHB_SLV_ERR_EN
  localparam int         E_LOW = 1;
  localparam logic [1:0] E_RSP = 2'b01;
`else
  localparam int         E_LOW = 0;
  localparam logic [1:0] E_RSP = 2'b00;
`endif

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0004;
  localparam logic [31:0] D2 = 32'h3333_0008;
  localparam logic [31:0] D3 = 32'h4444_000C;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic        hreadyin  [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic [1:0]  hresp     [2];

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rin;
    logic [31:0] exp_rd;
  } row_t;

  row_t pipe_rows [$];
  row_t busy_rows [$];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hreadyin(hreadyin[0]), .hwdata(hwdata[0]),
    .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0])
  );

  ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hreadyin(hreadyin[1]), .hwdata(hwdata[1]),
    .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  function automatic row_t mk(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic rin, input logic [31:0] exp_rd);
    row_t r;
    r.tr = tr; r.wr = wr; r.a = a; r.wd = wd; r.rin = rin; r.exp_rd = exp_rd;
    return r;
  endfunction

  // Samples each cycle of a data phase until hreadyout=1, then steps past the completing edge.
  task automatic wait_ready(input int d, output int low, output logic [31:0] rd,
                            output logic [1:0] rsp0, output logic [1:0] rsp);
    bit done;
    done = 1'b0;
    low  = 0;
    rd   = '0;
    rsp0 = '0;
    rsp  = '0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge hclk);
      if (k == 0) rsp0 = hresp[d];
      if (hreadyout[d]) begin
        rd   = hrdata[d];
        rsp  = hresp[d];
        done = 1'b1;
      end else begin
        low++;
      end
      step();
    end
    if (!done) check("ready timeout", 32'd0, 32'd1);
  endtask

  task automatic xfer_chk(input string tag, input int d, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd, input int exp_low,
                          input logic [31:0] exp_rd, input logic [1:0] exp_rsp);
    int          low;
    logic [31:0] rd;
    logic [1:0]  rsp0, rsp;
    haddr[d]    = a;
    htrans[d]   = T_NSEQ;
    hwrite[d]   = wr;
    hsize[d]    = sz;
    hreadyin[d] = 1'b1;
    step();
    htrans[d] = T_IDLE;
    hwdata[d] = wd;
    wait_ready(d, low, rd, rsp0, rsp);
    hwdata[d] = '0;
    check({tag, " waits"}, 32'(low), 32'(exp_low));
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " resp first"}, 32'(rsp0), 32'(exp_rsp));
    check({tag, " resp last"}, 32'(rsp), 32'(exp_rsp));
  endtask

  // Drives one bus cycle on the zero-wait instance and checks it completes with no stall.
  task automatic run_row(input string tag, input row_t r);
    htrans[0]   = r.tr;
    hwrite[0]   = r.wr;
    haddr[0]    = r.a;
    hsize[0]    = SZ_W;
    hwdata[0]   = r.wd;
    hreadyin[0] = r.rin;
    @(negedge hclk);
    check({tag, " ready"}, 32'(hreadyout[0]), 32'd1);
    check({tag, " resp"}, 32'(hresp[0]), 32'd0);
    check({tag, " rdata"}, hrdata[0], r.exp_rd);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          low;
    logic [31:0] rd;
    logic [1:0]  rsp0, rsp;

    hresetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      haddr[d] = '0; htrans[d] = T_IDLE; hwrite[d] = 1'b0; hsize[d] = SZ_W;
      hreadyin[d] = 1'b1; hwdata[d] = '0;
    end
    step();
    step();
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ready u%0d", d), 32'(hreadyout[d]), 32'd1);
      check($sformatf("reset resp u%0d", d), 32'(hresp[d]), 32'd0);
      check($sformatf("reset rdata u%0d", d), hrdata[d], 32'd0);
    end
    step();
    hresetn = 1'b1;
    step();

    // Byte and halfword lane selection, zero wait states.
    xfer_chk("clear w0",   0, 1'b1, 32'h8000_0000, SZ_W, 32'h0000_0000, 0, 32'h0, 2'b00);
    xfer_chk("byte w1",    0, 1'b1, 32'h8000_0001, SZ_B, 32'hFFFF_80FF, 0, 32'h0, 2'b00);
    xfer_chk("byte rd",    0, 1'b0, 32'h8000_0000, SZ_W, 32'h0,         0, 32'h0000_8000, 2'b00);
    xfer_chk("half w2",    0, 1'b1, 32'h8000_0002, SZ_H, 32'h1234_5678, 0, 32'h0, 2'b00);
    xfer_chk("half rd",    0, 1'b0, 32'h8000_0000, SZ_W, 32'h0,         0, 32'h1234_8000, 2'b00);
    xfer_chk("byte w0",    0, 1'b1, 32'h8000_0000, SZ_B, 32'hAAAA_AA5A, 0, 32'h0, 2'b00);
    xfer_chk("byte0 rd",   0, 1'b0, 32'h8000_0000, SZ_W, 32'h0,         0, 32'h1234_805A, 2'b00);

    // Back-to-back pipelined writes then reads, plus write-then-read of one word.
    pipe_rows.push_back(mk(T_NSEQ, 1'b1, 32'h8000_0000, 32'h0, 1'b1, 32'h0));
    pipe_rows.push_back(mk(T_NSEQ, 1'b1, 32'h8000_0004, D0,    1'b1, 32'h0));
    pipe_rows.push_back(mk(T_NSEQ, 1'b1, 32'h8000_0008, D1,    1'b1, 32'h0));
    pipe_rows.push_back(mk(T_NSEQ, 1'b0, 32'h8000_0000, D2,    1'b1, 32'h0));
    pipe_rows.push_back(mk(T_SEQ,  1'b0, 32'h8000_0004, 32'h0, 1'b1, D0));
    pipe_rows.push_back(mk(T_SEQ,  1'b0, 32'h8000_0008, 32'h0, 1'b1, D1));
    pipe_rows.push_back(mk(T_NSEQ, 1'b1, 32'h8000_000C, 32'h0, 1'b1, D2));
    pipe_rows.push_back(mk(T_NSEQ, 1'b0, 32'h8000_000C, D3,    1'b1, 32'h0));
    pipe_rows.push_back(mk(T_IDLE, 1'b0, 32'h8000_0000, 32'h0, 1'b1, D3));
    pipe_rows.push_back(mk(T_IDLE, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0));
    foreach (pipe_rows[i]) run_row($sformatf("pipe%0d", i), pipe_rows[i]);

    // IDLE, BUSY and hreadyin=0 cycles interleaved with real accesses.
    busy_rows.push_back(mk(T_BUSY, 1'b1, 32'h8000_0010, 32'h0,         1'b1, 32'h0));
    busy_rows.push_back(mk(T_IDLE, 1'b1, 32'h8000_0014, 32'h0,         1'b1, 32'h0));
    busy_rows.push_back(mk(T_NSEQ, 1'b1, 32'h8000_0010, 32'h0,         1'b1, 32'h0));
    busy_rows.push_back(mk(T_BUSY, 1'b0, 32'h8000_0014, 32'h5555_AAAA, 1'b1, 32'h0));
    busy_rows.push_back(mk(T_NSEQ, 1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 32'h0));
    busy_rows.push_back(mk(T_IDLE, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h5555_AAAA));
    busy_rows.push_back(mk(T_NSEQ, 1'b1, 32'h8000_0010, 32'h0,         1'b0, 32'h0));
    busy_rows.push_back(mk(T_IDLE, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 32'h0));
    busy_rows.push_back(mk(T_IDLE, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0));
    foreach (busy_rows[i]) run_row($sformatf("busy%0d", i), busy_rows[i]);
    xfer_chk("busy readback", 0, 1'b0, 32'h8000_0010, SZ_W, 32'h0, 0, 32'h5555_AAAA, 2'b00);

    // Window misses and unaligned halfwords.
    xfer_chk("miss wr",    0, 1'b1, 32'h9000_0000, SZ_W, 32'hBAD0_BAD0, E_LOW, 32'h0, E_RSP);
    xfer_chk("unal rd",    0, 1'b0, 32'h8000_0003, SZ_H, 32'h0,         E_LOW, 32'h0, E_RSP);
    xfer_chk("unal wr",    0, 1'b1, 32'h8000_0003, SZ_H, 32'hFFFF_FFFF, E_LOW, 32'h0, E_RSP);
    xfer_chk("miss rd",    0, 1'b0, 32'h9000_0000, SZ_W, 32'h0,         E_LOW, 32'h0, E_RSP);
    xfer_chk("idx0 kept",  0, 1'b0, 32'h8000_0000, SZ_W, 32'h0,         0,     D0,    2'b00);

    // Three wait states per data phase.
    xfer_chk("ws3 wr",     1, 1'b1, 32'h8000_0010, SZ_W, 32'hDEAD_BEEF, 3, 32'h0, 2'b00);
    xfer_chk("ws3 rd",     1, 1'b0, 32'h8000_0010, SZ_W, 32'h0,         3, 32'hDEAD_BEEF, 2'b00);

    // Read accepted on the completing cycle of a write to the same word.
    haddr[1] = 32'h8000_0014; htrans[1] = T_NSEQ; hwrite[1] = 1'b1; hsize[1] = SZ_W;
    step();
    hwrite[1] = 1'b0;
    hwdata[1] = 32'hCAFE_F00D;
    wait_ready(1, low, rd, rsp0, rsp);
    check("ws3 pipe wr waits", 32'(low), 32'd3);
    htrans[1] = T_IDLE;
    hwdata[1] = '0;
    wait_ready(1, low, rd, rsp0, rsp);
    check("ws3 pipe rd waits", 32'(low), 32'd3);
    check("ws3 pipe rd data", rd, 32'hCAFE_F00D);

    // Reset during the wait cycles of a write aborts it.
    xfer_chk("ws3 pre",    1, 1'b1, 32'h8000_0020, SZ_W, 32'h1111_1111, 3, 32'h0, 2'b00);
    haddr[1] = 32'h8000_0020; htrans[1] = T_NSEQ; hwrite[1] = 1'b1; hsize[1] = SZ_W;
    step();
    htrans[1] = T_IDLE;
    hwdata[1] = 32'h2222_2222;
    step();
    step();
    hresetn = 1'b0;
    step();
    @(negedge hclk);
    check("rst mid ready", 32'(hreadyout[1]), 32'd1);
    check("rst mid resp", 32'(hresp[1]), 32'd0);
    check("rst mid rdata", hrdata[1], 32'd0);
    step();
    hresetn   = 1'b1;
    hwdata[1] = '0;
    xfer_chk("rst kept",   1, 1'b0, 32'h8000_0020, SZ_W, 32'h0, 3, 32'h1111_1111, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter WAIT_STATES, default 1 (range 0..7): data-phase wait cycles inserted per valid access.
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000: base of the 256-byte decoded window.
REQ-003 hclk  input  1  single clock; all state changes on rising edge.
REQ-004 hresetn  input  1  synchronous, active-low reset, sampled on rising edge of hclk.
REQ-005 haddr  input  32  address-phase address.
REQ-006 htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 hwrite  input  1  1 = write, 0 = read (address phase).
REQ-008 hsize  input  3  000 byte, 001 halfword, 010 word; others are treated as word.
REQ-009 hreadyin  input  1  bus HREADY from the master side.
REQ-010 hwdata  input  32  write data, valid in the data phase.
REQ-011 hrdata  output  32  read data, valid when hreadyout=1 in a read data phase.
REQ-012 hreadyout  output  1  slave ready; 0 extends the data phase.
REQ-013 hresp  output  2  00 OKAY, 01 ERROR.

Function
REQ-014 Storage: 64 x 32-bit words, indexed by haddr[7:2]; contents are not reset.
REQ-015 Address phase accepted when hreadyin=1 && hreadyout=1 && htrans[1]=1; haddr, hsize and hwrite are registered in that cycle.
REQ-016 IDLE or BUSY transfers, and cycles with hreadyin=0, are not accepted; the next cycle is a zero-wait OKAY with no storage access.
REQ-017 Hit: haddr[31:8]==BASE_ADDR[31:8].
REQ-018 Aligned: byte always; halfword needs haddr[0]=0; word needs haddr[1:0]=00.
REQ-019 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-020 IDLE to WAIT on an accepted valid access when WAIT_STATES>0; counter is loaded with WAIT_STATES and hreadyout=0 while it is nonzero.
REQ-021 WAIT: the counter decrements each cycle; at 0, hreadyout=1 and the state returns to IDLE (or re-enters WAIT on a pipelined acceptance).
REQ-022 With WAIT_STATES=0, the data phase completes in the cycle after acceptance with hreadyout=1.
REQ-023 Write commit:
  - occurs at the rising edge ending the data-phase cycle where hreadyout=1;
  - only the byte lanes selected by the registered hsize and haddr[1:0] are written, little-endian;
  - unselected lanes keep their old contents.
REQ-024 Read: hrdata = full addressed word while hreadyout=1 in a read data phase; hrdata = 0 in all other cycles.
REQ-025 Pipelining: a new address phase may be accepted in the same cycle the previous data phase completes.
REQ-026 Back-to-back write then read of the same word returns the newly written data.
REQ-027 Every data phase that is not an error returns hresp=00.
REQ-028 Under ERR_EN, an accepted access that misses or is unaligned gets a two-cycle ERROR:
  - ERR1: hreadyout=0, hresp=01;
  - ERR2: hreadyout=1, hresp=01, then IDLE;
  - no storage is written.
REQ-029 In ERR2 a new address phase may be accepted.

Reset
REQ-030 While hresetn=0 at a rising edge, the FSM goes to IDLE, the counter is cleared and registered address/control is invalidated.
REQ-031 Output reset values: hreadyout=1, hresp=00, hrdata=0.
REQ-032 Reset asserted mid-data-phase aborts the transfer and no storage write occurs.

Configuration
REQ-033 Macro AHB_SLV_ERR_EN: when defined, a miss or unaligned access gets the two-cycle ERROR of REQ-028.
REQ-034 When AHB_SLV_ERR_EN is undefined, a miss or unaligned access gets a normal OKAY response with the same wait states, writes are discarded and reads return 0; ERR1 and ERR2 are not built.

Verification
REQ-035 Byte write 8'h80 to 8000_0001, then read 8000_0000 with WAIT_STATES=0 -> write completes with hreadyout=1, hresp=00; read returns 32'h0000_8000.
REQ-036 WAIT_STATES=3, word write 32'hDEAD_BEEF to 8000_0010, then read it back -> hreadyout low for exactly 3 cycles in each data phase; read returns DEAD_BEEF.
REQ-037 Pipelined NONSEQ writes to 8000_0000/04/08, then SEQ reads of the same addresses, no idle cycles between them -> reads return the values written; no extra wait cycles with WAIT_STATES=0.
REQ-038 With AHB_SLV_ERR_EN, access to 9000_0000 and halfword to 8000_0003:
  - each gives hresp=01 with hreadyout 0 then 1 over two cycles;
  - the word at index 0 is unchanged.
  Without the macro, both give hresp=00 and the reads return 0.
REQ-039 hresetn=0 driven during a WAIT-state write to 8000_0020 -> next cycle hreadyout=1, hresp=00, hrdata=0; the word at 8000_0020 is unchanged.
REQ-040 htrans=IDLE and BUSY cycles interleaved with a valid access -> those cycles cause no access and zero-wait OKAY; the valid access completes normally.
